// File: rtl/pipe_pkg.sv
// Shared pipeline constants: next-PC op encodings and front-end reset/flush defaults.
package pipe_pkg;

   localparam logic [1:0] NPC_SEQ  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_JAL  = 2'b10;
   localparam logic [1:0] NPC_JALR = 2'b11;

   // An all-zero word decodes as a no-op with every write enable low.
   localparam logic [31:0] FLUSH_INST_DEF = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

endpackage

// File: rtl/npc_gen.sv
// Combinational redirect decision and target computation from the EX-stage control-flow fields.
module npc_gen
   import pipe_pkg::*;
(
   input  logic [1:0]  ex_npc_op,
   input  logic        br_taken,
   input  logic [31:0] pc_ex,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   output logic        is_branch,
   output logic [31:0] target
);

   logic [31:0] pc_rel;
   logic [31:0] reg_rel;

   // Both adds wrap at 2^32; a misaligned target is forwarded as-is.
   assign pc_rel  = pc_ex + ex_imm;
   assign reg_rel = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;

   always_comb begin
      is_branch = 1'b0;
      target    = pc_rel;
      case (ex_npc_op)
         NPC_SEQ:  is_branch = 1'b0;
         NPC_BR:   is_branch = br_taken;
         NPC_JAL:  is_branch = 1'b1;
         NPC_JALR: begin
            is_branch = 1'b1;
            target    = reg_rel;
         end
         default:  is_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/if_id_stage.sv
// Pipeline front end: PC register, next-PC selection and IF/ID register with stall and flush.
// Optional IF_PERF_CNT_EN adds stall and flush event counters.
module if_id_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] FLUSH_INST = FLUSH_INST_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_stop,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_data,
   input  logic [1:0]  ex_npc_op,
   input  logic [31:0] pc_ex,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        br_taken,
   output logic        is_branch,
   output logic [31:0] pc_if,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc4_id,
   output logic        valid_id
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] cnt_stall,
   output logic [31:0] cnt_flush
`endif
);

   logic [31:0] target;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] pc4_id_q, pc4_id_d;
   logic        valid_q, valid_d;

   npc_gen u_npc_gen (
      .ex_npc_op (ex_npc_op),
      .br_taken  (br_taken),
      .pc_ex     (pc_ex),
      .ex_imm    (ex_imm),
      .ex_rs1    (ex_rs1),
      .is_branch (is_branch),
      .target    (target)
   );

   // A redirect overrides a stall: any held wrong-path instruction is dropped.
   always_comb begin
      pc_d     = pc_q;
      inst_d   = inst_q;
      pc_id_d  = pc_id_q;
      pc4_id_d = pc4_id_q;
      valid_d  = valid_q;
      if (is_branch) begin
         pc_d     = target;
         inst_d   = FLUSH_INST;
         pc_id_d  = 32'h0;
         pc4_id_d = 32'h0;
         valid_d  = 1'b0;
      end else if (!load_stop) begin
         pc_d     = pc_q + 32'd4;
         inst_d   = irom_data;
         pc_id_d  = pc_q;
         pc4_id_d = pc_q + 32'd4;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         inst_q   <= FLUSH_INST;
         pc_id_q  <= 32'h0;
         pc4_id_q <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         pc_id_q  <= pc_id_d;
         pc4_id_q <= pc4_id_d;
         valid_q  <= valid_d;
      end
   end

   assign irom_addr = pc_q;
   assign pc_if     = pc_q;
   assign inst_id   = inst_q;
   assign pc_id     = pc_id_q;
   assign pc4_id    = pc4_id_q;
   assign valid_id  = valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] cnt_stall_q, cnt_stall_d;
   logic [31:0] cnt_flush_q, cnt_flush_d;

   always_comb begin
      cnt_stall_d = cnt_stall_q;
      cnt_flush_d = cnt_flush_q;
      if (is_branch) cnt_flush_d = cnt_flush_q + 32'd1;
      else if (load_stop) cnt_stall_d = cnt_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_stall_q <= 32'h0;
         cnt_flush_q <= 32'h0;
      end else begin
         cnt_stall_q <= cnt_stall_d;
         cnt_flush_q <= cnt_flush_d;
      end
   end

   assign cnt_stall = cnt_stall_q;
   assign cnt_flush = cnt_flush_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Front end of the 5-stage pipeline: PC register, next-PC generation and IF/ID pipeline register.
- Resolves control-flow redirects from the EX-stage fields and drives is_branch to the ID/EX register.
- Holds the PC and the IF/ID contents during load-use stalls (load_stop).
- Inserts a bubble into IF/ID on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; first fetch address.
- FLUSH_INST, 32'h0000_0000, instruction word written into inst_id on flush; decodes as no-op, all write enables 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_stop  in  1  load-use stall from hazard unit; freezes PC and IF/ID
- irom_addr  out  32  instruction ROM address, equals pc_if
- irom_data  in  32  instruction word, combinational read of irom_addr
- ex_npc_op  in  2  EX-stage next-PC op: 00 seq, 01 cond branch, 10 jal, 11 jalr
- pc_ex  in  32  PC of the instruction in EX
- ex_imm  in  32  immediate of the instruction in EX
- ex_rs1  in  32  forwarded rs1 value in EX (jalr base)
- br_taken  in  1  branch comparison result from EX ALU
- is_branch  out  1  redirect: flush IF/ID and ID/EX this cycle
- pc_if  out  32  current fetch PC
- inst_id  out  32  instruction in ID
- pc_id  out  32  PC of inst_id
- pc4_id  out  32  pc_id+4, used as the link value
- valid_id  out  1  inst_id is a real instruction, not a bubble

Behaviour:
- Reset (asynchronous): pc_if=RESET_PC, inst_id=FLUSH_INST, pc_id=0, pc4_id=0, valid_id=0.
- is_branch (combinational) = (ex_npc_op==10) | (ex_npc_op==11) | (ex_npc_op==01 & br_taken).
- Redirect target:
  - op 01 or 10: pc_ex+ex_imm.
  - op 11: (ex_rs1+ex_imm) & 32'hFFFF_FFFE.
  - All adds are 32-bit; carry is discarded, so addresses wrap at 2^32.
- PC update each posedge, highest priority first:
  1. is_branch: pc_if <= target.
  2. load_stop: pc_if holds.
  3. Otherwise: pc_if <= pc_if+4.
- IF/ID update each posedge, highest priority first:
  1. is_branch: inst_id=FLUSH_INST, pc_id=0, pc4_id=0, valid_id=0.
  2. load_stop: all fields hold.
  3. Otherwise: inst_id=irom_data, pc_id=pc_if, pc4_id=pc_if+4, valid_id=1.
- Simultaneous is_branch and load_stop: redirect wins in both registers. A held stalled instruction on the wrong path is discarded. The hazard unit never produces this combination; the block still defines it.
- Timing: fetch-to-ID latency is 1 cycle. Redirect penalty is 2 bubbles: IF/ID is flushed here and ID/EX is flushed by is_branch.
- First cycle after reset release: irom_addr=RESET_PC; valid_id rises on the following edge.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- A misaligned target (bit 1 set) is passed through unchanged; the block raises no exception.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - cnt_stall (32): increments every cycle load_stop=1 and is_branch=0.
  - cnt_flush (32): increments every cycle is_branch=1.
- Both counters reset to 0 and wrap modulo 2^32.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_JAL/NPC_JALR 2-bit localparams;
  - FLUSH_INST default;
  - RESET_PC default.
- Sub-module npc_gen: combinational; inputs ex_npc_op, br_taken, pc_ex, ex_imm, ex_rs1; outputs is_branch and target. Instantiated once.

Test Plan:
- Reset, then release with irom returning addr-derived words, no stalls → pc_if steps 0,4,8,…; from the second edge pc_id trails pc_if by 4 and valid_id=1.
- load_stop high for 2 cycles at pc_if=0x10 → pc_if=0x10 and inst_id/pc_id unchanged for 2 edges, then pc_if=0x14.
- ex_npc_op=01, pc_ex=0x20, ex_imm=0x40, br_taken=1 → is_branch=1, next pc_if=0x60, inst_id=FLUSH_INST, valid_id=0. The same stimulus with br_taken=0 → no redirect, pc_if+4.
- ex_npc_op=11, ex_rs1=0x1001, ex_imm=0x2 → next pc_if=0x1002; op 10 with pc_ex=0xFFFF_FFF0, imm=0x20 → pc_if=0x10 (wrap).
- is_branch and load_stop together (op 10, pc_ex=0x8, imm=0x8) → pc_if=0x10 and IF/ID flushed; rst_n pulsed between edges → all outputs reset immediately.
- With IF_PERF_CNT_EN defined: 3 stall cycles and 2 redirects → cnt_stall=3, cnt_flush=2; a reset returns both counters to 0.
